// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad key FIFO.
// Capture FSM state encoding, STATUS bit positions and key code width.
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam int STAT_OVF   = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/kp_fifo_core.sv
// kp_fifo_core: key code storage with read/write pointers and occupancy count.
// Show-ahead read port (RDATA is always the head entry). A write into a full
// FIFO is accepted only when a pop happens in the same cycle. CLR overrides all.
module kp_fifo_core
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             WR,
  input  logic [KEY_W-1:0] WDATA,
  input  logic             RD,
  output logic [KEY_W-1:0] RDATA,
  output logic [3:0]       COUNT
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [KEY_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  // A pop needs data; a push needs room, which a same-cycle pop provides.
  assign do_rd = RD & (COUNT != 4'd0);
  assign do_wr = WR & ((COUNT != DEPTH_C) | do_rd);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= 4'd0;
    end else if (CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= 4'd0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   COUNT <= COUNT + 4'd1;
        2'b01:   COUNT <= COUNT - 4'd1;
        default: COUNT <= COUNT;
      endcase
    end
  end

  // Storage array; data only, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (do_wr && !CLR) mem[wr_ptr] <= WDATA;
  end

  assign RDATA = mem[rd_ptr];

endmodule

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo: buffers key codes from the keypad driver for the MCU.
// A KEY_VALID rising edge starts a settle delay of CAPTURE_DLY cycles, after
// which KEY_CODE is sampled into the FIFO and IRQ pulses for one cycle.
// Optional feature macro: KEYPAD_FIFO_OVF_CNT_EN adds the OVF_CNT port and a
// saturating count of dropped writes.
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CAPTURE_DLY = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             KEY_VALID,
  input  logic [KEY_W-1:0] KEY_CODE,
  input  logic             RD,
  input  logic             CLR,
  output logic [7:0]       DOUT,
  output logic [7:0]       STATUS,
`ifdef KEYPAD_FIFO_OVF_CNT_EN
  output logic [7:0]       OVF_CNT,
`endif
  output logic             IRQ
);

  localparam logic [3:0] DEPTH_C  = 4'(DEPTH);
  localparam logic [3:0] DLY_LOAD = 4'(CAPTURE_DLY - 1);

  cap_state_t       state;
  logic [3:0]       dly_cnt;
  logic             kv_q;
  logic             key_edge;
  logic             wr_req;
  logic [KEY_W-1:0] rdata;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic             accept;
  logic             drop;
  logic             ovf;

  assign key_edge = KEY_VALID & ~kv_q;

  // KEY_VALID history for rising-edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) kv_q <= 1'b0;
    else        kv_q <= KEY_VALID;
  end

  // Capture sequencer: edge -> settle delay -> one sampling cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      dly_cnt <= 4'd0;
    end else if (CLR) begin
      state   <= IDLE;
      dly_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (key_edge) begin
            state   <= WAIT;
            dly_cnt <= DLY_LOAD;
          end
        end
        WAIT: begin
          if (dly_cnt == 4'd0) state <= CAPTURE;
          else                 dly_cnt <= dly_cnt - 4'd1;
        end
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // KEY_CODE is sampled directly while in CAPTURE.
  assign wr_req = (state == CAPTURE);

  kp_fifo_core #(
    .DEPTH (DEPTH)
  ) u_core (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (CLR),
    .WR    (wr_req),
    .WDATA (KEY_CODE),
    .RD    (RD),
    .RDATA (rdata),
    .COUNT (count)
  );

  assign full  = (count == DEPTH_C);
  assign empty = (count == 4'd0);

  // Full implies non-empty, so a same-cycle RD always frees a slot.
  assign accept = wr_req & (~full | RD);
  assign drop   = wr_req & full & ~RD;

  // One-cycle interrupt after each stored key; suppressed by CLR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   IRQ <= 1'b0;
    else if (CLR) IRQ <= 1'b0;
    else          IRQ <= accept;
  end

  // Sticky overflow flag, cleared only by CLR or reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    ovf <= 1'b0;
    else if (CLR)  ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

`ifdef KEYPAD_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating count of dropped writes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    ovf_cnt <= 8'h00;
    else if (CLR)  ovf_cnt <= 8'h00;
    else if (drop) ovf_cnt <= sat_inc8(ovf_cnt);
  end

  assign OVF_CNT = ovf_cnt;
`endif

  // Status byte and show-ahead data port.
  always_comb begin
    STATUS             = 8'h00;
    STATUS[STAT_OVF]   = ovf;
    STATUS[STAT_FULL]  = full;
    STATUS[STAT_EMPTY] = empty;
    STATUS[3:0]        = count;
  end

  assign DOUT = empty ? 8'h00 : {4'h0, rdata};

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Bench for keypad_key_fifo: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_keypad_key_fifo;

  localparam int DEPTH = 8;
  localparam int DLY   = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       RD;
  logic       CLR;
  logic [7:0] DOUT;
  logic [7:0] STATUS;
  logic       IRQ;
`ifdef KEYPAD_FIFO_OVF_CNT_EN
  logic [7:0] OVF_CNT;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  keypad_key_fifo #(
    .DEPTH       (DEPTH),
    .CAPTURE_DLY (DLY)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE),
    .RD        (RD),
    .CLR       (CLR),
    .DOUT      (DOUT),
    .STATUS    (STATUS),
`ifdef KEYPAD_FIFO_OVF_CNT_EN
    .OVF_CNT   (OVF_CNT),
`endif
    .IRQ       (IRQ)
  );

  // Reference model: queue of stored codes plus a pending-capture deadline.
  logic [3:0] mq[$];
  bit         m_ovf;
  int         m_ovf_cnt;
  bit         m_busy;
  int         m_cap;
  int         cyc;
  bit         m_kv_prev;
  bit         m_irq;

  function automatic void model_reset();
    mq.delete();
    m_ovf     = 1'b0;
    m_ovf_cnt = 0;
    m_busy    = 1'b0;
    m_irq     = 1'b0;
    m_kv_prev = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs applied this cycle.
  function automatic void model_cycle();
    bit edge_seen;
    bit busy0;
    bit wr;
    bit acc;
    if (!RST_N) begin
      model_reset();
      cyc++;
      return;
    end
    edge_seen = KEY_VALID && !m_kv_prev;
    busy0     = m_busy;
    if (CLR) begin
      mq.delete();
      m_ovf     = 1'b0;
      m_ovf_cnt = 0;
      m_busy    = 1'b0;
      m_irq     = 1'b0;
    end else begin
      wr  = busy0 && (cyc == m_cap);
      acc = 1'b0;
      if (RD && mq.size() > 0) void'(mq.pop_front());
      if (wr) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(KEY_CODE);
          acc = 1'b1;
        end else begin
          m_ovf = 1'b1;
          if (m_ovf_cnt < 255) m_ovf_cnt++;
        end
      end
      m_irq = acc;
      if (wr) m_busy = 1'b0;
      if (!busy0 && edge_seen) begin
        m_busy = 1'b1;
        m_cap  = cyc + DLY + 1;
      end
    end
    m_kv_prev = KEY_VALID;
    cyc++;
  endfunction

  function automatic logic [7:0] exp_status();
    int n;
    n = mq.size();
    return {m_ovf, n == DEPTH, n == 0, 1'b0, 4'(n)};
  endfunction

  function automatic logic [7:0] exp_dout();
    return (mq.size() > 0) ? {4'h0, mq[0]} : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One clock: update model, clock the DUT, compare all outputs.
  task automatic step();
    model_cycle();
    @(posedge CLK);
    #1;
    check("status", STATUS, exp_status());
    check("dout", DOUT, exp_dout());
    check("irq", {7'h0, IRQ}, {7'h0, m_irq});
`ifdef KEYPAD_FIFO_OVF_CNT_EN
    check("ovf_cnt", OVF_CNT, 8'(m_ovf_cnt));
`endif
  endtask

  task automatic press(input logic [3:0] code);
    KEY_CODE  = code;
    KEY_VALID = 1'b1;
    step();
    KEY_VALID = 1'b0;
    repeat (6) step();
  endtask

  task automatic pop();
    RD = 1'b1;
    step();
    RD = 1'b0;
  endtask

  initial begin
    int irq_hits;
    int irq_at;
    RST_N     = 1'b0;
    KEY_VALID = 1'b0;
    KEY_CODE  = 4'h0;
    RD        = 1'b0;
    CLR       = 1'b0;
    cyc       = 0;
    m_cap     = 0;
    model_reset();

    // Reset values
    #2;
    check("rst_status", STATUS, 8'h20);
    check("rst_dout", DOUT, 8'h00);
    check("rst_irq", {7'h0, IRQ}, 8'h00);
    step();
    step();
    RST_N = 1'b1;
    repeat (3) step();

    // Single key 0xA, level KEY_VALID
    KEY_CODE  = 4'hA;
    KEY_VALID = 1'b1;
    step();
    irq_hits = 0;
    irq_at   = -1;
    for (int k = 1; k <= 10; k++) begin
      if (IRQ) begin
        irq_hits++;
        irq_at = k;
      end
      if (k == 3) KEY_VALID = 1'b0;
      if (k < 10) step();
    end
    check("irq_pulses", 8'(irq_hits), 8'd1);
    check("irq_latency", 8'(irq_at), 8'd6);
    check("one_status", STATUS, 8'h01);
    check("one_dout", DOUT, 8'h0A);
    pop();
    check("one_read_status", STATUS, 8'h20);

    // Code changes after the edge: the late value is stored
    KEY_CODE  = 4'h5;
    KEY_VALID = 1'b1;
    step();
    step();
    KEY_CODE  = 4'h3;
    KEY_VALID = 1'b0;
    repeat (6) step();
    check("late_code", DOUT, 8'h03);
    pop();

    // Nine writes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) press(4'(i));
    check("ovf_status", STATUS, 8'hC8);
`ifdef KEYPAD_FIFO_OVF_CNT_EN
    check("ovf_cnt_one", OVF_CNT, 8'h01);
`endif
    for (int i = 1; i <= 8; i++) begin
      check("order", DOUT, 8'(i));
      pop();
    end
    check("drained_status", STATUS, 8'hA0);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("clr_status", STATUS, 8'h20);

    // Full FIFO with RD on the capture cycle
    for (int i = 0; i < 8; i++) press(4'($urandom));
    KEY_CODE  = 4'hE;
    KEY_VALID = 1'b1;
    step();
    KEY_VALID = 1'b0;
    repeat (4) step();
    RD = 1'b1;
    step();
    RD = 1'b0;
    check("full_rd_irq", {7'h0, IRQ}, 8'h01);
    check("full_rd_status", STATUS, 8'h48);
    repeat (7) pop();
    check("full_rd_last", DOUT, 8'h0E);
    pop();
    check("full_rd_empty", STATUS, 8'h20);

    // CLR during the settle delay with three entries queued
    for (int i = 0; i < 3; i++) press(4'(i + 4));
    KEY_CODE  = 4'h7;
    KEY_VALID = 1'b1;
    step();
    KEY_VALID = 1'b0;
    step();
    step();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    check("clr_wait_status", STATUS, 8'h20);
    for (int k = 0; k < 8; k++) begin
      step();
      check("clr_wait_irq", {7'h0, IRQ}, 8'h00);
    end
    check("clr_wait_after", STATUS, 8'h20);

    // Asynchronous reset during the settle delay
    press(4'h1);
    press(4'h2);
    KEY_CODE  = 4'h9;
    KEY_VALID = 1'b1;
    step();
    KEY_VALID = 1'b0;
    step();
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check("async_rst_status", STATUS, 8'h20);
    check("async_rst_dout", DOUT, 8'h00);
    step();
    RST_N = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("rst_wait_irq", {7'h0, IRQ}, 8'h00);
    end
    check("rst_wait_status", STATUS, 8'h20);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      KEY_VALID = ($urandom_range(0, 3) == 0);
      KEY_CODE  = 4'($urandom);
      RD        = (k < 400) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 4);
      CLR       = ($urandom_range(0, 79) == 0);
      step();
    end
    KEY_VALID = 1'b0;
    RD        = 1'b0;
    CLR       = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_key_fifo.md
# keypad_key_fifo

Buffers 4-bit key codes from the keypad driver so the MCU can read them at its own pace. It detects each new-key event and waits a fixed settle delay so the driver's output register has updated. It then samples the key code into a small FIFO and raises a one-cycle interrupt pulse. It sits between the keypad driver and the MCU input-port multiplexer, presenting one data port and one status port.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..8
- CAPTURE_DLY, 4, CLK cycles between the KEY_VALID rising edge and the KEY_CODE sample; 1..15

- CLK  in  1  system clock; all state updates on its rising edge
- RST_N  in  1  asynchronous active-low reset
- KEY_VALID  in  1  new-key indication from the keypad driver; level or pulse; only rising edges count
- KEY_CODE  in  4  key code from the keypad driver's output register
- RD  in  1  MCU read strobe; pops the head entry
- CLR  in  1  synchronous flush
- DOUT  out  8  {4'b0, head key code}; 8'h00 when empty
- STATUS  out  8  {OVF, FULL, EMPTY, 1'b0, COUNT[3:0]}
- IRQ  out  1  one-cycle pulse per successful write
- OVF_CNT  out  8  overflow count; present only with KEYPAD_FIFO_OVF_CNT_EN

## Operation
- Edge detect: kv_q is KEY_VALID registered; edge = KEY_VALID & ~kv_q.
- Capture FSM states:
  - IDLE: on edge, load the delay counter with CAPTURE_DLY-1 and go to WAIT.
  - WAIT: decrement the counter; at 0 go to CAPTURE.
  - CAPTURE: sample KEY_CODE, issue a write request, go to IDLE.
  - Edges seen while in WAIT or CAPTURE are ignored.
- Write when not full: store the code at wr_ptr, increment wr_ptr (wraps mod DEPTH), increment COUNT, assert IRQ on the next cycle.
- Write when full: the entry is dropped, sticky OVF sets, no IRQ.
- RD when not empty: increment rd_ptr (wraps), decrement COUNT. RD when empty: ignored, no state change.
- Write and RD in the same cycle:
  - Not empty: both take effect; COUNT unchanged, no overflow even if full.
  - Empty: the write takes effect, RD is ignored.
- CLR has priority over everything:
  - Pointers, COUNT, OVF and (if compiled in) OVF_CNT go to 0.
  - FSM goes to IDLE, any same-cycle write is discarded, IRQ stays 0.
- DOUT is combinational from the head entry (show-ahead).
- FULL = (COUNT==DEPTH); EMPTY = (COUNT==0).

## Timing
- Reset values: DOUT 8'h00, STATUS 8'h20, IRQ 0, OVF_CNT 8'h00; FSM IDLE, kv_q 0.
- Sample latency: KEY_CODE is sampled CAPTURE_DLY+1 cycles after the cycle in which the edge is seen.
- Status update: COUNT and STATUS update on the CAPTURE clock edge.
- IRQ: high for exactly the one cycle after that edge.
- DOUT: shows a new head on the cycle after a pop.
- Reset mid-WAIT: the pending capture is lost; no write occurs after RST_N releases.

## Configuration
- KEYPAD_FIFO_OVF_CNT_EN defined:
  - The OVF_CNT port and an 8-bit counter exist.
  - The counter increments on every dropped write and saturates at 8'hFF.
  - It clears on CLR or reset.
- Undefined: no OVF_CNT port; overflow is reported only by the sticky OVF bit.

## Structure
- Package keypad_pkg holds:
  - The capture FSM state enum (IDLE, WAIT, CAPTURE).
  - STATUS bit index constants (OVF=7, FULL=6, EMPTY=5).
  - Width constant KEY_W=4.
- Sub-module kp_fifo_core holds storage, pointers, COUNT and the full/empty logic. Its ports are CLK, RST_N, CLR, WR, WDATA, RD, RDATA, COUNT. The edge detector and capture FSM stay in the top level.

## Test plan
- Reset, idle: STATUS=8'h20, DOUT=8'h00, IRQ=0.
- KEY_CODE=4'hA, KEY_VALID rising, CAPTURE_DLY=4:
  - IRQ pulses exactly once, 6 cycles after the edge.
  - STATUS=8'h01, DOUT=8'h0A.
  - Then RD: STATUS=8'h20.
- KEY_CODE changes to 4'h3 two cycles after the edge: 4'h3 is stored, not the earlier value.
- Nine writes with codes 1..9, no reads:
  - STATUS=8'hC8 (OVF set, FULL set, COUNT=8).
  - Reads return 1..8 in order.
  - OVF_CNT=1 when the macro is defined.
- FIFO full, RD asserted on the CAPTURE cycle: COUNT stays 8, OVF stays 0, IRQ pulses, and the last entry is the new code.
- CLR asserted during WAIT with 3 entries queued: STATUS=8'h20 next cycle, no IRQ, nothing written afterwards.
